// File: rtl/parking_gate_ctrl_pkg.sv
// parking_gate_ctrl_pkg: shared state encoding, lane tags and sizes for the parking gate front end
package parking_gate_ctrl_pkg;
    localparam int NUM_SPOTS = 4;
    localparam int SPOT_W = 2;
    typedef enum logic [1:0] {IDLE, REQ, OPEN, CLEAR} state_t;
    typedef enum logic {LANE_ENTRY, LANE_EXIT} lane_t;
endpackage

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: raw sensors, capacity FSM handshake and barrier outputs of the gate controller
interface parking_gate_ctrl_if;
    import parking_gate_ctrl_pkg::*;
    logic                 i_entry_sensor;
    logic                 i_exit_sensor;
    logic [SPOT_W-1:0]    i_exit_spot;
    logic [NUM_SPOTS-1:0] i_spot_sensor;
    logic                 i_open_door_in;
    logic                 i_full_in;
    logic                 o_enter;
    logic                 o_exit;
    logic [SPOT_W-1:0]    o_switch;
    logic [NUM_SPOTS-1:0] o_e;
    logic                 o_gate_up;
    logic                 o_deny;
    logic                 o_busy;
    modport master (
        input  i_entry_sensor, i_exit_sensor, i_exit_spot, i_spot_sensor, i_open_door_in, i_full_in,
        output o_enter, o_exit, o_switch, o_e, o_gate_up, o_deny, o_busy
    );
    modport slave (
        output i_entry_sensor, i_exit_sensor, i_exit_spot, i_spot_sensor, i_open_door_in, i_full_in,
        input  o_enter, o_exit, o_switch, o_e, o_gate_up, o_deny, o_busy
    );
endinterface

// File: rtl/parking_gate_ctrl_debounce.sv
// sensor_debounce: 2-flop synchroniser, saturating stability counter and registered rising-edge pulse
module sensor_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_deb,
    output logic o_rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_CYC - 1);
    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;
    logic             r_rise;
    logic             w_stable;
    // this cycle completes the required run of synced-high samples
    assign w_stable = r_s2 && (r_cnt >= CNT_ARM);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_deb  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_cnt  <= !r_s2 ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
            r_deb  <= w_stable;
            r_rise <= w_stable && !r_deb;
        end
    end
    assign o_deb  = r_deb;
    assign o_rise = r_rise;
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: debounces entry/exit lanes, arbitrates requests to the capacity FSM and drives the barrier
module parking_gate_ctrl
    import parking_gate_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int OPEN_CYC     = 16
) (
    input  logic                clk,
    input  logic                rst,
    parking_gate_ctrl_if.master bus
);
    localparam int TMR_W = $clog2(OPEN_CYC);
    state_t               r_state;
    state_t               w_next;
    lane_t                r_lane;
    logic                 r_pend_en;
    logic                 r_pend_ex;
    logic                 r_deny;
    logic [TMR_W-1:0]     r_timer;
    logic [SPOT_W-1:0]    r_switch;
    logic [NUM_SPOTS-1:0] r_e1;
    logic [NUM_SPOTS-1:0] r_e2;
    logic                 w_deb_en;
    logic                 w_deb_ex;
    logic                 w_rise_en;
    logic                 w_rise_ex;
    logic                 w_win;
    logic                 w_refuse;
    logic                 w_lane_clear;

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_en (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (bus.i_entry_sensor),
        .o_deb  (w_deb_en),
        .o_rise (w_rise_en)
    );

    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_ex (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (bus.i_exit_sensor),
        .o_deb  (w_deb_ex),
        .o_rise (w_rise_ex)
    );

    assign w_win        = (r_state == IDLE) && (r_pend_en || r_pend_ex);
    // full only ever vetoes an entry; it never opens the gate on its own
    assign w_refuse     = !bus.i_open_door_in || (bus.i_full_in && bus.o_enter);
    assign w_lane_clear = (r_lane == LANE_EXIT) ? !w_deb_ex : !w_deb_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_win ? REQ : IDLE;
            REQ:     w_next = w_refuse ? IDLE : OPEN;
            OPEN:    w_next = (r_timer == '0) ? CLEAR : OPEN;
            CLEAR:   w_next = w_lane_clear ? IDLE : CLEAR;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_enter   = (r_state == REQ) && (r_lane == LANE_ENTRY);
        bus.o_exit    = (r_state == REQ) && (r_lane == LANE_EXIT);
        bus.o_gate_up = (r_state == OPEN) || (r_state == CLEAR);
        bus.o_busy    = r_state != IDLE;
        bus.o_deny    = r_deny;
        bus.o_switch  = r_switch;
        bus.o_e       = r_e2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane    <= LANE_ENTRY;
            r_pend_en <= 1'b0;
            r_pend_ex <= 1'b0;
            r_deny    <= 1'b0;
            r_timer   <= '0;
            r_switch  <= '0;
            r_e1      <= '0;
            r_e2      <= '0;
        end else begin
            r_e1      <= bus.i_spot_sensor;
            r_e2      <= r_e1;
            r_deny    <= (r_state == REQ) && w_refuse;
            r_timer   <= (r_state == REQ) ? TMR_W'(OPEN_CYC - 1) :
                         (r_state == OPEN && r_timer != '0) ? r_timer - TMR_W'(1) : r_timer;
            // exit wins ties; a lane edge arriving while its slot is full is dropped
            r_pend_ex <= (w_win && r_pend_ex) ? 1'b0 : r_pend_ex || w_rise_ex;
            r_pend_en <= (w_win && !r_pend_ex) ? 1'b0 : r_pend_en || w_rise_en;
            if (w_win) r_lane <= r_pend_ex ? LANE_EXIT : LANE_ENTRY;
            if (w_win && r_pend_ex) r_switch <= bus.i_exit_spot;
        end
    end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed lane scenarios plus random sensor traffic, checked every cycle
// against a lane/capacity reference model and a capacity FSM wrapped around the controller.
module tb_parking_gate_ctrl;
    localparam int D    = 4;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       entry_s, exit_s;
    logic [1:0] spot_sel;
    logic [3:0] spots;

    parking_gate_ctrl_if bif();
    assign bif.i_entry_sensor = entry_s;
    assign bif.i_exit_sensor  = exit_s;
    assign bif.i_exit_spot    = spot_sel;
    assign bif.i_spot_sensor  = spots;

    parking_gate_ctrl #(.DEBOUNCE_CYC(D), .OPEN_CYC(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // capacity FSM the controller fronts
    int cap = 4;
    assign bif.i_full_in      = cap == 0;
    assign bif.i_open_door_in = bif.o_enter ? (cap > 0) :
                                bif.o_exit  ? (cap < 4 && !bif.o_e[bif.o_switch]) : 1'b0;
    always @(posedge clk) if (bif.i_open_door_in) cap <= bif.o_enter ? cap - 1 : cap + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model: raw sample history per lane, pending slots, presented request,
    // remaining minimum-hold cycles and a wait-for-lane-clear flag
    bit [D+1:0] sh_en, sh_ex;
    bit         m_deb_en, m_deb_ex, m_rise_en, m_rise_ex, m_pend_en, m_pend_ex;
    int         m_req = -1;
    int         m_hold, m_gl;
    bit         m_wait, m_deny;
    bit [1:0]   m_sw;
    bit [3:0]   m_e1, m_e;
    int         m_cap = 4;

    task automatic model_reset();
        sh_en = '0; sh_ex = '0;
        m_deb_en = 0; m_deb_ex = 0; m_rise_en = 0; m_rise_ex = 0;
        m_pend_en = 0; m_pend_ex = 0;
        m_req = -1; m_hold = 0; m_wait = 0; m_gl = 0; m_deny = 0;
        m_sw = '0; m_e1 = '0; m_e = '0;
    endtask

    task automatic model_step();
        bit ok, nd, npe, npx, nwait, ndeny;
        int nreq, nhold;
        bit [1:0] nsw;
        if (rst) begin
            model_reset();
            return;
        end
        npe = m_pend_en | m_rise_en;
        npx = m_pend_ex | m_rise_ex;
        nreq = -1; nsw = m_sw; ndeny = 0; nhold = m_hold; nwait = m_wait;
        if (m_req < 0 && m_hold == 0 && !m_wait && (m_pend_en || m_pend_ex)) begin
            nreq = m_pend_ex ? 1 : 0;
            if (m_pend_ex) begin npx = 0; nsw = spot_sel; end
            else npe = 0;
        end
        if (m_req >= 0) begin
            ok = (m_req == 0) ? (m_cap > 0) : (m_cap < 4 && !m_e[m_sw]);
            if (ok) begin
                nhold = HOLD;
                m_gl = m_req;
                m_cap += (m_req == 0) ? -1 : 1;
            end else ndeny = 1;
        end else if (m_hold > 0) begin
            nhold = m_hold - 1;
            nwait = m_hold == 1;
        end else if (m_wait && !(m_gl == 1 ? m_deb_ex : m_deb_en)) nwait = 0;
        sh_en = {sh_en[D:0], entry_s};
        sh_ex = {sh_ex[D:0], exit_s};
        nd = &sh_en[D+1:2]; m_rise_en = nd && !m_deb_en; m_deb_en = nd;
        nd = &sh_ex[D+1:2]; m_rise_ex = nd && !m_deb_ex; m_deb_ex = nd;
        m_e = m_e1; m_e1 = spots;
        m_pend_en = npe; m_pend_ex = npx; m_req = nreq; m_sw = nsw;
        m_deny = ndeny; m_hold = nhold; m_wait = nwait;
    endtask

    bit chk_on = 0;
    always @(negedge clk) if (chk_on) begin
        chk("enter",  bif.o_enter,   m_req == 0);
        chk("exit",   bif.o_exit,    m_req == 1);
        chk("switch", bif.o_switch,  m_sw);
        chk("e_sync", bif.o_e,       m_e);
        chk("gate",   bif.o_gate_up, m_hold > 0 || m_wait);
        chk("deny",   bif.o_deny,    m_deny);
        chk("busy",   bif.o_busy,    m_req >= 0 || m_hold > 0 || m_wait);
        chk("cap",    cap,           m_cap);
        chk("excl",   bif.o_enter & bif.o_exit, 0);
        chk("gate_in_req", bif.o_gate_up & (bif.o_enter | bif.o_exit), 0);
    end

    int cyc, first_ent, first_ext, n_ent, n_ext, n_deny, n_gate;

    task automatic clr_stats();
        cyc = 0; first_ent = -1; first_ext = -1;
        n_ent = 0; n_ext = 0; n_deny = 0; n_gate = 0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #2;
            cyc++;
            n_ent  += int'(bif.o_enter);
            n_ext  += int'(bif.o_exit);
            n_deny += int'(bif.o_deny);
            n_gate += int'(bif.o_gate_up);
            if (bif.o_enter && first_ent < 0) first_ent = cyc;
            if (bif.o_exit && first_ext < 0) first_ext = cyc;
        end
    endtask

    task automatic car_in();
        entry_s = 1; tick(10); entry_s = 0; tick(30);
    endtask

    task automatic car_out();
        exit_s = 1; tick(10); exit_s = 0; tick(30);
    endtask

    initial begin
        int mode_en, left_en, mode_ex, left_ex;
        entry_s = 0; exit_s = 0; spot_sel = 0; spots = 0;
        model_reset();
        chk_on = 1;
        tick(3);
        rst = 0;
        clr_stats();
        tick(2);
        chk("rst_busy", bif.o_busy, 0);
        chk("rst_gate", bif.o_gate_up, 0);
        chk("rst_e", bif.o_e, 0);

        // one car held 20 cycles on an empty lot
        clr_stats();
        entry_s = 1; tick(20); entry_s = 0; tick(20);
        chk("s1_first_enter", first_ent, 8);
        chk("s1_enters", n_ent, 1);
        chk("s1_gate_cycles", n_gate, 17);
        chk("s1_cap", cap, 3);
        chk("s1_model_cap", m_cap, 3);

        // bouncing sensor never settles
        clr_stats();
        repeat (8) begin entry_s = 1; tick(3); entry_s = 0; tick(1); end
        tick(10);
        chk("s2_enters", n_ent, 0);
        chk("s2_gate", n_gate, 0);

        // fill the lot, then one more is refused
        clr_stats();
        repeat (3) car_in();
        chk("s3_enters", n_ent, 3);
        chk("s3_cap_full", cap, 0);
        clr_stats();
        car_in();
        chk("s3_enter_full", n_ent, 1);
        chk("s3_deny", n_deny, 1);
        chk("s3_gate", n_gate, 0);
        chk("s3_cap", cap, 0);

        // two leave, then simultaneous entry and exit
        repeat (2) car_out();
        chk("s4_cap_pre", cap, 2);
        clr_stats();
        entry_s = 1; exit_s = 1; tick(10); entry_s = 0; exit_s = 0; tick(70);
        chk("s4_first_exit", first_ext, 8);
        chk("s4_first_enter", first_ent, 27);
        chk("s4_gate", n_gate, 34);
        chk("s4_cap", cap, 2);

        // exit checked against an occupied spot, then a vacated one
        spot_sel = 2; spots = 4'b0100; tick(3);
        clr_stats();
        car_out();
        chk("s5_switch", bif.o_switch, 2);
        chk("s5_exits", n_ext, 1);
        chk("s5_deny", n_deny, 1);
        chk("s5_gate", n_gate, 0);
        chk("s5_cap", cap, 2);
        spots = 4'b0000; tick(3);
        clr_stats();
        car_out();
        chk("s5b_deny", n_deny, 0);
        chk("s5b_gate", n_gate, 17);
        chk("s5b_cap", cap, 3);

        // reset while the barrier is in its hold window
        clr_stats();
        entry_s = 1; tick(10); entry_s = 0; tick(6);
        chk("s6_gate_pre", bif.o_gate_up, 1);
        rst = 1;
        model_reset();
        #1;
        chk("s6_gate_async", bif.o_gate_up, 0);
        chk("s6_busy_async", bif.o_busy, 0);
        tick(2);
        rst = 0;
        tick(5);
        chk("s6_cap_after_rst", cap, 2);
        clr_stats();
        car_in();
        chk("s6_enters", n_ent, 1);
        chk("s6_gate", n_gate, 17);
        chk("s6_cap", cap, 1);

        // random traffic: quiet, held and bouncing segments on both lanes
        left_en = 0; left_ex = 0; mode_en = 0; mode_ex = 0;
        for (int c = 0; c < 4000; c++) begin
            if (left_en == 0) begin mode_en = int'($urandom_range(0, 2)); left_en = int'($urandom_range(1, 30)); end
            if (left_ex == 0) begin mode_ex = int'($urandom_range(0, 2)); left_ex = int'($urandom_range(1, 30)); end
            entry_s = (mode_en == 0) ? 1'b0 : (mode_en == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            exit_s  = (mode_ex == 0) ? 1'b0 : (mode_ex == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            left_en--;
            left_ex--;
            if ($urandom_range(0, 40) == 0) spots = 4'($urandom);
            if (!exit_s && $urandom_range(0, 10) == 0) spot_sel = 2'($urandom);
            if (c == 2000) begin
                rst = 1;
                model_reset();
                tick(2);
                rst = 0;
            end
            tick(1);
        end
        entry_s = 0; exit_s = 0;
        tick(60);
        chk("final_cap", cap, m_cap);
        chk("final_busy", bif.o_busy, 0);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
